// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU Signal codes, alu_op/funct codes,
// MULTU sequencer states and the ID-stage decoder.
package alu_pkg;

  localparam int unsigned AluW = 32;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } alu_sig_e;

  typedef enum logic [1:0] {
    OpMem    = 2'b00,
    OpBranch = 2'b01,
    OpRtype  = 2'b10,
    OpRsvd   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnMultu = 6'b011001;

  typedef enum logic {
    StIdle = 1'b0,
    StMul  = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic [2:0] sig;
    logic       illegal;
    logic       is_mul;
  } dec_t;

  // Undecodable ops still issue as ADD so the datapath sees a defined control word.
  function automatic dec_t decode(logic [1:0] op, logic [5:0] fn);
    dec_t d;
    d.sig     = AluAdd;
    d.illegal = 1'b0;
    d.is_mul  = 1'b0;
    case (op)
      OpMem:    d.sig = AluAdd;
      OpBranch: d.sig = AluSub;
      OpRtype: begin
        case (fn)
          FnAdd:   d.sig = AluAdd;
          FnSub:   d.sig = AluSub;
          FnAnd:   d.sig = AluAnd;
          FnOr:    d.sig = AluOr;
          FnSlt:   d.sig = AluSlt;
          FnMultu: d.is_mul = 1'b1;
          default: d.illegal = 1'b1;
        endcase
      end
      default:  d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multu_seq.sv
// Unsigned shift-add multiplier: one partial-product step per clock, result into hilo.
module multu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned MUL_STEPS = W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] hilo
);

  localparam int unsigned CntW = $clog2(MUL_STEPS);

  mul_state_e      state_q;
  logic [2*W-1:0]  p_q;
  logic [2*W-1:0]  p_step;
  logic [W-1:0]    m_q;
  logic [CntW-1:0] cnt_q;
  logic [W:0]      t;

  // The adder result keeps its carry as the new top bit of P.
  always_comb begin
    t      = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
    p_step = {t, p_q[W-1:1]};
  end

  assign busy = (state_q == StMul);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      hilo    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              p_q     <= {{W{1'b0}}, b};
              m_q     <= a;
              cnt_q   <= '0;
              state_q <= StMul;
            end
          end
          StMul: begin
            p_q   <= p_step;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(MUL_STEPS - 1)) begin
              hilo    <= p_step;
              done    <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ID/EX issue stage: decodes ALUOp+funct, registers operands and ALU Signal with a
// valid/ready handshake, and hands MULTU to the shift-add sequencer.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned MUL_STEPS = W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     alu_op,
  input  logic [5:0]     funct,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic           flush,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [2:0]     alu_signal,
  output logic           out_valid,
  output logic           illegal,
  output logic           mul_busy,
  output logic           mul_done,
  output logic [2*W-1:0] hilo
);

  dec_t dec;
  logic accept;
  logic mul_start;

  assign dec       = decode(alu_op, funct);
  assign in_ready  = ~mul_busy;
  // Flush wins over a simultaneous transfer; the offered instruction is dropped.
  assign accept    = in_valid & in_ready & ~flush;
  assign mul_start = accept & dec.is_mul;

  multu_seq #(
    .W         (W),
    .MUL_STEPS (MUL_STEPS)
  ) u_multu_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .abort (flush),
    .a     (a_in),
    .b     (b_in),
    .busy  (mul_busy),
    .done  (mul_done),
    .hilo  (hilo)
  );

  // Operands and Signal only load on a non-MULTU accept; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_signal <= '0;
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      if (accept && !dec.is_mul) begin
        alu_a      <= a_in;
        alu_b      <= b_in;
        alu_signal <= dec.sig;
        out_valid  <= 1'b1;
        illegal    <= dec.illegal;
      end
    end
  end

endmodule
